ic_hc_huffman_coding_controller: RTL and testbench
==================================================

IC_HC_HUFFMAN_CODING_CONTROLLER -- requirements
Module: ic_hc_huffman_coding_controller

Interface
REQ-001 Parameter COEF_W, default 13, coefficient width in two's complement; must match the preparation stage input.
REQ-002 Parameter ADDR_W, default 6, coefficient buffer address width; the buffer holds 64 zig-zag-ordered coefficients per block.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  a quantized 8x8 block is ready in the buffer.
REQ-006 last_nz  input  ADDR_W  zig-zag index of the last nonzero coefficient (0 when every AC coefficient is zero); sampled when start is accepted.
REQ-007 out_stall  input  1  downstream almost-full; the downstream stage guarantees one entry of slack.
REQ-008 rd_en  output  1  buffer read strobe.
REQ-009 rd_addr  output  ADDR_W  buffer read address.
REQ-010 rd_data  input  COEF_W  buffer read data, valid exactly 1 cycle after rd_en.
REQ-011 DC_enable, AC_enable, EOB_enable  output  1 each  one-hot strobes to the preparation stage.
REQ-012 coef_data  output  COEF_W  coefficient to the preparation stage; equals rd_data in the strobe cycle, 0 otherwise.
REQ-013 busy  output  1  high from start acceptance until done.
REQ-014 done  output  1  single-cycle pulse on block completion.

Function
REQ-015 States: IDLE, RUN, EOB, FIN.
REQ-016 IDLE: start=1 is accepted; last_nz and last_idx are captured, idx is cleared to 0, and the state moves to RUN. busy rises in the next cycle.
REQ-017 RUN: each cycle with out_stall=0 drives rd_en=1, rd_addr=idx, and increments idx. A cycle with out_stall=1 issues no read and holds idx.
REQ-018 The strobe is asserted exactly 1 cycle after each read: DC_enable for idx 0 and AC_enable for idx 1..last_idx. At most one strobe is asserted per cycle.
REQ-019 After the read of last_idx is issued, RUN moves to EOB.
REQ-020 EOB state:
- Waits until out_stall=0, then emits EOB_enable exactly 1 cycle later (after the final data strobe) and moves to FIN.
- EOB is suppressed when last_nz=63; in that case the state goes directly to FIN.
REQ-021 FIN: done=1 for one cycle, busy falls, and the state returns to IDLE.
REQ-022 The earliest new start is accepted in the cycle after done, giving an unstalled block latency of last_idx+4 cycles from start to done.
REQ-023 start asserted while busy is ignored and is not queued.
REQ-024 idx saturates at 63 and never wraps.
REQ-025 last_idx=0 (DC only): the block is DC then EOB, with no AC strobes.

Reset
REQ-026 While reset_n=0:
- state=IDLE and idx=0;
- rd_en, DC_enable, AC_enable, EOB_enable, busy and done are 0;
- rd_addr=0 and coef_data=0.
REQ-027 Reset asserted mid-block abandons the block within the same edge; no strobe or done is emitted after reset deasserts.

Configuration
REQ-028 Macro IC_HC_CTRL_SKIP_TRAILING_EN.
- Defined: last_idx=last_nz, so trailing zero coefficients are never read.
- Undefined: last_idx=63, so all AC coefficients are streamed; trailing zeros reach the preparation stage only as zero-run counts; the EOB rule of REQ-020 is unchanged.

Structure
REQ-029 A shared package ic_hc_pkg holds:
- the state encoding;
- the COEF_W and ADDR_W defaults;
- the constant LAST_COEF_IDX=63.
REQ-030 One sub-module is natural: ic_hc_rd_pipe, a 1-stage register aligning strobe type with rd_data. Everything else is flat.

Verification
REQ-031 Bench scenarios:
- Macro on, last_nz=5, no stall -> DC at idx 0, AC at idx 1..5, EOB; done 9 cycles after start.
- last_nz=63, no stall -> 1 DC and 63 AC strobes, no EOB, done once.
- Macro off, last_nz=2 -> 63 AC strobes, then EOB.
- out_stall toggled every other cycle during RUN -> no read while stalled, strobe order and data unchanged, at most 1 strobe after the stall rises.
- Reset asserted at idx=10 -> all outputs 0 the next cycle; a fresh start completes a full block correctly.
- start held high through a whole block -> exactly one block is processed per acceptance, with re-acceptance in the cycle after done.

Source files
------------

// File: rtl/ic_hc_pkg.sv
// Shared definitions for the Huffman coding controller: FSM states, strobe kinds, size defaults.
package ic_hc_pkg;

   localparam int COEF_W_DEF    = 13;
   localparam int ADDR_W_DEF    = 6;
   localparam int LAST_COEF_IDX = 63;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_EOB  = 2'd2,
      ST_FIN  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      STB_NONE = 2'd0,
      STB_DC   = 2'd1,
      STB_AC   = 2'd2,
      STB_EOB  = 2'd3
   } stb_e;

endpackage

// File: rtl/ic_hc_huffman_coding_controller_rd_pipe.sv
// ic_hc_rd_pipe: one register stage that lines the strobe kind up with buffer read data.
module ic_hc_rd_pipe
   import ic_hc_pkg::*;
#(
   parameter int COEF_W = COEF_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        stb_type,
   input  logic [COEF_W-1:0] rd_data,
   output logic              dc_enable,
   output logic              ac_enable,
   output logic              eob_enable,
   output logic [COEF_W-1:0] coef_data
);

   logic [1:0] stb_q;
   logic [1:0] stb_d;

   always_comb begin
      stb_d = stb_type;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stb_q <= 2'(STB_NONE);
      end else begin
         stb_q <= stb_d;
      end
   end

   // Read data arrives one cycle after the read, exactly when the registered kind is presented.
   always_comb begin
      dc_enable  = (stb_q == 2'(STB_DC));
      ac_enable  = (stb_q == 2'(STB_AC));
      eob_enable = (stb_q == 2'(STB_EOB));
      if (dc_enable || ac_enable) begin
         coef_data = rd_data;
      end else begin
         coef_data = {COEF_W{1'b0}};
      end
   end

endmodule

// File: rtl/ic_hc_huffman_coding_controller.sv
// Streams one zig-zag block from the coefficient buffer to the preparation stage.
// Optional macro IC_HC_CTRL_SKIP_TRAILING_EN stops reading at last_nz instead of index 63.
module ic_hc_huffman_coding_controller
   import ic_hc_pkg::*;
#(
   parameter int COEF_W = COEF_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] last_nz,
   input  logic              out_stall,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [COEF_W-1:0] rd_data,
   output logic              DC_enable,
   output logic              AC_enable,
   output logic              EOB_enable,
   output logic [COEF_W-1:0] coef_data,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST_COEF_IDX);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] last_idx_q, last_idx_d;
   logic              skip_eob_q, skip_eob_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              rd_en_s;
   logic [ADDR_W-1:0] rd_addr_s;
   stb_e              stb_s;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= {ADDR_W{1'b0}};
         last_idx_q <= {ADDR_W{1'b0}};
         skip_eob_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         last_idx_q <= last_idx_d;
         skip_eob_q <= skip_eob_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      last_idx_d = last_idx_q;
      skip_eob_d = skip_eob_q;
      rd_en_s    = 1'b0;
      rd_addr_s  = {ADDR_W{1'b0}};
      stb_s      = STB_NONE;
      case (state_q)
         ST_IDLE: begin
            // The done cycle itself is not an accept cycle; the next one is.
            if (start && !done_q) begin
               state_d    = ST_RUN;
               idx_d      = {ADDR_W{1'b0}};
`ifdef IC_HC_CTRL_SKIP_TRAILING_EN
               last_idx_d = last_nz;
`else
               last_idx_d = LAST_A;
`endif
               skip_eob_d = (last_nz == LAST_A);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!out_stall) begin
               rd_en_s   = 1'b1;
               rd_addr_s = idx_q;
               if (idx_q == {ADDR_W{1'b0}}) begin
                  stb_s = STB_DC;
               end else begin
                  stb_s = STB_AC;
               end
               if (idx_q == last_idx_q) begin
                  state_d = skip_eob_q ? ST_FIN : ST_EOB;
               end else begin
                  state_d = ST_RUN;
               end
               if (idx_q != LAST_A) begin
                  idx_d = idx_q + ADDR_W'(1);
               end else begin
                  idx_d = idx_q;
               end
            end else begin
               idx_d = idx_q;
            end
         end
         ST_EOB: begin
            // EOB rides the read pipe so it always trails the final data strobe.
            if (!out_stall) begin
               stb_s   = STB_EOB;
               state_d = ST_FIN;
            end else begin
               state_d = ST_EOB;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_q == ST_FIN);
   end

   assign rd_en   = rd_en_s;
   assign rd_addr = rd_addr_s;
   assign busy    = busy_q;
   assign done    = done_q;

   ic_hc_rd_pipe #(
      .COEF_W (COEF_W)
   ) u_rd_pipe (
      .clk        (clk),
      .reset_n    (reset_n),
      .stb_type   (stb_s),
      .rd_data    (rd_data),
      .dc_enable  (DC_enable),
      .ac_enable  (AC_enable),
      .eob_enable (EOB_enable),
      .coef_data  (coef_data)
   );

endmodule

// File: tb/tb_ic_hc_huffman_coding_controller.sv
// Scoreboard bench: stimulus pushes the expected strobe stream, a negedge monitor pops and compares.
module tb_ic_hc_huffman_coding_controller;

   localparam int CW = 13;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [AW-1:0] last_nz;
   logic          out_stall;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [CW-1:0] rd_data;
   logic          dc_en, ac_en, eob_en;
   logic [CW-1:0] coef_data;
   logic          busy, done;

   typedef struct packed {
      logic [1:0]    kind;
      logic [CW-1:0] data;
   } exp_t;

   exp_t          q[$];
   logic [CW-1:0] mem[64];
   int            checks = 0;
   int            errors = 0;
   int            done_cnt = 0;

   ic_hc_huffman_coding_controller dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .last_nz    (last_nz),
      .out_stall  (out_stall),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .DC_enable  (dc_en),
      .AC_enable  (ac_en),
      .EOB_enable (eob_en),
      .coef_data  (coef_data),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Coefficient buffer: data one cycle after a read, junk otherwise.
   always @(posedge clk) begin
      rd_data <= rd_en ? mem[rd_addr] : CW'($urandom);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0h required %0h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic int li_of(input int ln);
`ifdef IC_HC_CTRL_SKIP_TRAILING_EN
      return ln;
`else
      return 63;
`endif
   endfunction

   function automatic int lat_of(input int ln);
      return (ln == 63) ? li_of(ln) + 3 : li_of(ln) + 4;
   endfunction

   task automatic fill_mem(input int ln);
      for (int i = 0; i < 64; i++) begin
         if (i < ln) mem[i] = CW'($urandom);
         else if (i == ln) mem[i] = CW'($urandom_range(1, 4095));
         else mem[i] = '0;
      end
   endtask

   // Expected stream: DC, AC for 1..last_idx, then EOB unless the last coefficient is index 63.
   task automatic push_block(input int ln);
      q.push_back({2'd0, mem[0]});
      for (int i = 1; i <= li_of(ln); i++) q.push_back({2'd1, mem[i]});
      if (ln != 63) q.push_back({2'd2, {CW{1'b0}}});
   endtask

   // Monitor: compare every presented strobe with the head of the scoreboard.
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (dc_en || ac_en || eob_en) begin
            chk("onehot", $countones({dc_en, ac_en, eob_en}), 1);
            if (q.size() == 0) begin
               chk("unexpected_strobe", {29'd0, dc_en, ac_en, eob_en}, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("kind", dc_en ? 0 : (ac_en ? 1 : 2), e.kind);
               chk("coef", coef_data, e.data);
            end
         end else begin
            chk("coef_idle", coef_data, 0);
         end
         if (out_stall) chk("rd_while_stall", rd_en, 0);
         if (done) done_cnt++;
      end
   end

   task automatic run_block(input int ln, input bit stall, input bit pulse, input int exp_lat);
      int cyc;
      int d0;
      bit got;
      fill_mem(ln);
      push_block(ln);
      d0 = done_cnt;
      last_nz = AW'(ln);
      out_stall = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      last_nz = AW'($urandom);
      chk("busy_rise", busy, 1);
      cyc = 1;
      got = done;
      while (!got && cyc < 400) begin
         if (stall) out_stall = ~out_stall;
         start = pulse && (cyc == 3);
         @(posedge clk); #1;
         cyc++;
         got = done;
      end
      start = 1'b0;
      out_stall = 1'b0;
      chk("done_seen", got, 1);
      if (exp_lat >= 0) chk("latency", cyc, exp_lat);
      @(posedge clk); #1;
      chk("busy_after_done", busy, 0);
      chk("queue_empty", q.size(), 0);
      chk("done_count", done_cnt - d0, 1);
   endtask

   task automatic wait_done(output bit got);
      int n = 0;
      got = 1'b0;
      while (!got && n < 400) begin
         @(posedge clk); #1;
         n++;
         got = done;
      end
   endtask

   initial begin
      bit got;
      int n;
      int d0;
      reset_n = 1'b0;
      start = 1'b0;
      out_stall = 1'b0;
      last_nz = '0;
      for (int i = 0; i < 64; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rd_en", rd_en, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_strobes", {dc_en, ac_en, eob_en}, 0);
      chk("rst_busy_done", {busy, done}, 0);
      chk("rst_coef", coef_data, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      run_block(5, 1'b0, 1'b0, lat_of(5));
      run_block(63, 1'b0, 1'b0, lat_of(63));
      run_block(2, 1'b0, 1'b1, lat_of(2));
      run_block(0, 1'b0, 1'b0, lat_of(0));
      for (int k = 0; k < 4; k++) run_block(int'($urandom_range(0, 63)), 1'b1, 1'b0, -1);
      for (int k = 0; k < 3; k++) begin
         n = int'($urandom_range(0, 62));
         run_block(n, 1'b0, 1'b0, lat_of(n));
      end

      // Reset in the middle of a block at read index 10.
      fill_mem(40);
      push_block(40);
      last_nz = AW'(40);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!(rd_en && rd_addr == AW'(10)) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("reached_idx10", {31'd0, rd_en && rd_addr == AW'(10)}, 1);
      reset_n = 1'b0;
      @(posedge clk); #1;
      q.delete();
      chk("midrst_rd", {rd_en, rd_addr}, 0);
      chk("midrst_strobes", {dc_en, ac_en, eob_en}, 0);
      chk("midrst_busy_done", {busy, done}, 0);
      chk("midrst_coef", coef_data, 0);
      reset_n = 1'b1;
      d0 = done_cnt;
      repeat (4) @(posedge clk);
      #1;
      chk("post_rst_idle", {busy, done, rd_en}, 0);
      chk("post_rst_no_done", done_cnt - d0, 0);
      run_block(7, 1'b0, 1'b0, lat_of(7));

      // start held high: one block per acceptance, re-accepted the cycle after done.
      n = int'($urandom_range(0, 62));
      fill_mem(n);
      push_block(n);
      push_block(n);
      d0 = done_cnt;
      last_nz = AW'(n);
      start = 1'b1;
      wait_done(got);
      chk("held_done1", got, 1);
      @(posedge clk); #1;
      chk("held_gap_idle", busy, 0);
      @(posedge clk); #1;
      chk("held_reaccept", busy, 1);
      wait_done(got);
      start = 1'b0;
      chk("held_done2", got, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("held_no_third", busy, 0);
      chk("held_queue_empty", q.size(), 0);
      chk("held_done_count", done_cnt - d0, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
